// File: rtl/clkdiv_pkg.sv
// Shared types, constants and divisor helpers for the multi-channel clock divider.
package clkdiv_pkg;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } clkdiv_state_t;

    localparam int unsigned DIV_MIN = 2;

    // Any requested divisor below DIV_MIN is raised to DIV_MIN so a period is never degenerate.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        logic [31:0] r;
        if (d < 32'(DIV_MIN)) begin
            r = 32'(DIV_MIN);
        end else begin
            r = d;
        end
        return r;
    endfunction

    // High-phase length of the square wave: ceil(D/2), so odd divisors get the extra high cycle.
    function automatic logic [31:0] half_up(input logic [31:0] d);
        return (d + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: divisor register, phase counter, tick pulse and square-wave flops.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 10
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             en,
    input  logic             locked_in,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             tick,
    output logic             clk_out
);

    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] last_s;
    logic [CNT_W-1:0] half_s;
    logic             wrap_s;
    logic             tick_q;
    logic             tick_d;
    logic             clk_out_q;
    logic             clk_out_d;

    // Next divisor, counter, tick and square-wave level for this channel.
    always_comb begin
        last_s = div_q - CNT_W'(1);
        half_s = CNT_W'(half_up(32'(div_q)));
        wrap_s = (cnt_q == last_s);

        // The divisor is stored even while the channel is disabled.
        if (load) begin
            div_d = CNT_W'(clamp_div(32'(load_div)));
        end else begin
            div_d = div_q;
        end

        if (!en) begin
            cnt_d     = '0;
            tick_d    = 1'b0;
            clk_out_d = 1'b0;
        end else if (load) begin
            // Restart the period; a wrap on this same edge is suppressed.
            cnt_d     = '0;
            tick_d    = 1'b0;
            clk_out_d = (cnt_q < half_s);
        end else begin
            cnt_d     = wrap_s ? '0 : (cnt_q + CNT_W'(1));
            tick_d    = wrap_s & locked_in;
            clk_out_d = (cnt_q < half_s);
        end
    end

    // Channel state registers with synchronous reset to the default divisor.
    always_ff @(posedge refclk) begin
        if (rst) begin
            div_q     <= CNT_W'(DIV_DEFAULT);
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign tick    = tick_q;
    assign clk_out = clk_out_q;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel clock divider: config port decode, settle/lock FSM and NUM_CH divider channels.
module clock_divider_multi
    import clkdiv_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int CNT_W       = 16,
    parameter  int DIV_DEFAULT = 10,
    parameter  int LOCK_CYCLES = 16,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked
);

    localparam int              SC_W   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CH_W:0]   CH_LIM = (CH_W + 1)'(NUM_CH);
    localparam logic [SC_W-1:0] SC_END = SC_W'(LOCK_CYCLES - 1);

    clkdiv_state_t     state_q;
    clkdiv_state_t     state_d;
    logic [SC_W-1:0]   settle_q;
    logic [SC_W-1:0]   settle_d;
    logic              locked_q;
    logic              locked_d;
    logic              cfg_ready_q;
    logic              cfg_ready_d;
    logic              cfg_accept_s;
    logic              cfg_wr_s;
    logic [NUM_CH-1:0] load_s;

    // Handshake decode: only an accepted request to an existing channel writes anything.
    always_comb begin
        cfg_ready_d  = 1'b1;
        cfg_accept_s = cfg_valid & cfg_ready_q;
        cfg_wr_s     = cfg_accept_s & ({1'b0, cfg_ch} < CH_LIM);
        for (int i = 0; i < NUM_CH; i++) begin
            load_s[i] = cfg_wr_s & (cfg_ch == CH_W'(i));
        end
    end

    // Settle/lock FSM next state; a valid config always restarts the settle period.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        locked_d = locked_q;
        if (cfg_wr_s) begin
            state_d  = SETTLE;
            settle_d = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (settle_q == SC_END) begin
                        state_d  = LOCKED;
                        settle_d = '0;
                        locked_d = 1'b1;
                    end else begin
                        settle_d = settle_q + SC_W'(1);
                        locked_d = 1'b0;
                    end
                end
                LOCKED: begin
                    locked_d = 1'b1;
                end
                default: begin
                    state_d  = SETTLE;
                    settle_d = '0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    // Control registers; reset drops lock, restarts settling and closes the config port.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= SETTLE;
            settle_q    <= '0;
            locked_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            locked_q    <= locked_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    // Ticks are masked with the next lock value so tick never shows while locked reads low.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_ch (
            .refclk    (refclk),
            .rst       (rst),
            .en        (ch_en[g]),
            .locked_in (locked_d),
            .load      (load_s[g]),
            .load_div  (cfg_div),
            .tick      (tick[g]),
            .clk_out   (clk_out[g])
        );
    end

    assign cfg_ready = cfg_ready_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi: per-edge reference model feeds an expectation queue,
// a negedge monitor compares DUT outputs against it.
module tb_clock_divider_multi;

    // Six channels leave codes 6 and 7 of the 3-bit channel field unused, exercising bad-channel writes.
    localparam int NCH  = 6;
    localparam int CW   = 16;
    localparam int DDEF = 10;
    localparam int LOCK = 16;

    logic           clk;
    logic           rst;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [2:0]     cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic [NCH-1:0] ch_en;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk_out;
    logic           locked;

    typedef struct packed {
        logic           locked;
        logic           ready;
        logic [NCH-1:0] tick;
        logic [NCH-1:0] clk;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model state: divisor, cycles elapsed in current period, edges since last lock event.
    int m_div [NCH];
    int m_ph  [NCH];
    int m_since;
    bit m_ready;

    clock_divider_multi #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .DIV_DEFAULT (DDEF),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .refclk    (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .ch_en     (ch_en),
        .tick      (tick),
        .clk_out   (clk_out),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Predict outputs after the coming edge from the inputs now applied.
    task automatic model_edge();
        exp_t e;
        bit   wr;
        bit   lk;
        bit   ld;
        int   nd;
        e = '0;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_div[i] = DDEF;
                m_ph[i]  = 0;
            end
            m_ready = 1'b0;
            m_since = 0;
        end else begin
            wr = cfg_valid && m_ready && (int'(cfg_ch) < NCH);
            if (wr) m_since = 0;
            else if (m_since < 1000) m_since++;
            lk       = (m_since >= LOCK);
            e.locked = lk;
            e.ready  = 1'b1;
            m_ready  = 1'b1;
            for (int i = 0; i < NCH; i++) begin
                ld = wr && (int'(cfg_ch) == i);
                nd = ld ? ((int'(cfg_div) < 2) ? 2 : int'(cfg_div)) : m_div[i];
                if (!ch_en[i]) begin
                    m_ph[i] = 0;
                end else begin
                    e.clk[i]  = (m_ph[i] < (m_div[i] + 1) / 2);
                    e.tick[i] = !ld && lk && (m_ph[i] == m_div[i] - 1);
                    m_ph[i]   = ld ? 0 : (m_ph[i] + 1) % m_div[i];
                end
                m_div[i] = nd;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input int dv);
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_div   = CW'(dv);
        step();
        cfg_valid = 1'b0;
    endtask

    // Monitor: outputs are valid every cycle, so pop one expectation per falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (locked !== e.locked) begin
                n_miss++;
                $display("FAIL locked t=%0t got %b exp %b", $time, locked, e.locked);
            end
            if (cfg_ready !== e.ready) begin
                n_miss++;
                $display("FAIL cfg_ready t=%0t got %b exp %b", $time, cfg_ready, e.ready);
            end
            if (tick !== e.tick) begin
                n_miss++;
                $display("FAIL tick t=%0t got %b exp %b", $time, tick, e.tick);
            end
            if (clk_out !== e.clk) begin
                n_miss++;
                $display("FAIL clk_out t=%0t got %b exp %b", $time, clk_out, e.clk);
            end
        end
    end

    initial begin
        int b;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = 3'd0;
        cfg_div   = '0;
        ch_en     = {NCH{1'b1}};

        // Defaults: reset, lock after settle, /10 everywhere.
        repeat (3) step();
        rst = 1'b0;
        repeat (45) step();

        // Odd divisor on channel 1.
        cfg(1, 5);
        repeat (45) step();

        // Clamp of 0 and 1 on channel 2.
        cfg(2, 0);
        repeat (30) step();
        cfg(2, 1);
        repeat (30) step();

        // Highest valid channel, then two nonexistent channels while locked.
        cfg(5, 3);
        repeat (30) step();
        cfg(6, 9);
        repeat (5) step();
        cfg(7, 4);
        repeat (20) step();

        // Config storm during settle.
        cfg(0, 8);
        repeat (4) step();
        cfg(3, 6);
        repeat (4) step();
        cfg(4, 12);
        repeat (30) step();

        // Reset mid-settle after reprogramming channel 3.
        cfg(3, 7);
        repeat (5) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (40) step();

        // Channel disable with a simultaneous write to the same channel.
        ch_en[4] = 1'b0;
        cfg(4, 3);
        repeat (10) step();
        ch_en[4] = 1'b1;
        repeat (30) step();

        // Randomized traffic.
        repeat (2000) begin
            rst       = ($urandom_range(0, 299) == 0);
            cfg_valid = ($urandom_range(0, 39) == 0);
            cfg_ch    = 3'($urandom_range(0, 7));
            cfg_div   = CW'($urandom_range(0, 14));
            if ($urandom_range(0, 39) == 0) begin
                b = $urandom_range(0, NCH - 1);
                ch_en[b] = ~ch_en[b];
            end
            step();
        end
        rst       = 1'b0;
        cfg_valid = 1'b0;

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
